led_arbiter: RTL and testbench
==============================

# led_arbiter

Shares the board's six active-low LEDs between three independent pattern sources, such as the scroller, a UART activity indicator and a status display. Each source raises a request and supplies a 6-bit active-high pattern. The block grants exactly one source at a time in round-robin order, bounds each grant to a time slice while others are waiting, and drives the registered, inverted pattern onto the LED pins. It sits between the pattern generators and the top-level `leds` pins.

## Interface

- `SLICE_CYCLES`, default 27000000: maximum clock cycles a requester keeps the grant while another request is pending (1 s at 27 MHz). Legal range is 2 to 2^32-1.
- `IDLE_PATTERN`, default 6'b000000: active-high pattern shown when no source holds the grant.

- `clock`  in  1: system clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  3: `req[i]` high means requester i wants the LEDs; level-sensitive.
- `pattern0`, `pattern1`, `pattern2`  in  6 each: active-high patterns for requesters 0, 1 and 2. Sampled every cycle while that requester owns the LEDs.
- `grant`  out  3: one-hot owner, or 3'b000 when idle; registered.
- `busy`  out  1: OR of `grant`; registered.
- `leds`  out  6: active-low LED drive; registered.

## Operation

- States:
  - IDLE: no owner.
  - OWNED(k): requester k owns the LEDs, k in {0,1,2}.
- Round-robin pointer `last` holds the most recently granted index. The search order is last+1, last+2, last+3, all mod 3, so the previous owner is checked last.
- IDLE:
  - If `req` is nonzero, pick the first set bit in search order. Go to OWNED(pick), set `last`=pick and clear `slice_cnt`.
  - Otherwise stay in IDLE.
- OWNED(k): `slice_cnt` (32-bit) increments each cycle and saturates at SLICE_CYCLES-1.
- Release occurs when either:
  - `req[k]`=0, or
  - `slice_cnt`==SLICE_CYCLES-1 and another `req` bit is set.
- On release, arbitrate over `req` in the same cycle, with requester k excluded when it has dropped its request:
  - Winner found: go directly to OWNED(winner) with no idle gap, set `last`=winner and clear `slice_cnt`.
  - No winner: go to IDLE.
- When the slice expires with no contender, k keeps the grant and `slice_cnt` stays saturated. A contender arriving later causes a handover on the next edge.
- Output registers are loaded on every edge from the next state:
  - `grant` = one-hot(next owner), or 0.
  - `busy` = (next state != IDLE).
  - `leds` = ~pattern_next_owner, or ~IDLE_PATTERN when the next state is IDLE.
- While k owns the LEDs, changes on pattern_k appear on `leds` one cycle later. Patterns from non-owners are ignored.
- Reset, asynchronous and usable mid-operation:
  - state IDLE, `last`=2 so requester 0 wins first, `slice_cnt`=0;
  - `grant`=3'b000, `busy`=0, `leds`=~IDLE_PATTERN (6'b111111 by default);
  - any current ownership is dropped immediately.

## Timing

- Latency is one cycle. A request sampled at edge n gives `grant`, `busy` and `leds` valid after edge n.
- `grant` is never multi-hot and changes only on a clock edge.
- A requester dropping `req` at edge n loses `grant` after edge n. The new owner, if any, is visible after the same edge.
- Maximum continuous ownership under contention is SLICE_CYCLES cycles.
- Worst-case wait for a requester holding `req` high is 2*SLICE_CYCLES cycles.
- Simultaneous requests resolve by the pointer only; there is no fixed priority apart from the reset value of `last`.
- The output registers hold between changes; there is no combinational path from `req` or the patterns to any output.

## Test plan

All scenarios use SLICE_CYCLES=4 and IDLE_PATTERN=6'b000000.

- Reset with all `req` low: outputs read `grant`=000, `busy`=0, `leds`=6'b111111. Assert `reset` mid-grant: outputs return to these values asynchronously, without waiting for a clock edge.
- `req`=3'b111 from reset, all held: `grant` sequence is 001 ×4, 010 ×4, 100 ×4, 001 ×4, with no gap cycles. `leds` = ~pattern_owner throughout.
- `req`=3'b010 only, `pattern1`=6'b000101: after one edge, `grant`=010 and `leds`=6'b111010. Holding for 20 cycles keeps the grant. Raise `req[0]`: handover after the next edge.
- Owner 0 drops `req[0]` at cycle 2 of its slice while `req[2]`=1: `grant` goes 001 → 100 at the next edge and `slice_cnt` restarts.
- Owner drops `req` with no other request: `grant`=000, `busy`=0, `leds`=6'b111111 after one edge. Re-request after 3 idle cycles: round-robin continues from `last`.
- Change `pattern0` every cycle while requester 0 owns the LEDs: `leds` tracks ~`pattern0` delayed by one cycle. Toggling `pattern1` has no effect on `leds`.

Source files
------------

// File: rtl/led_arbiter.sv
// Round-robin arbiter sharing six active-low LEDs between three pattern sources.
// Each grant is time-sliced while other sources wait; all outputs are registered.
module led_arbiter #(
  parameter logic [31:0] SLICE_CYCLES = 32'd27000000,
  parameter logic [5:0]  IDLE_PATTERN = 6'b000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [5:0] pattern0,
  input  logic [5:0] pattern1,
  input  logic [5:0] pattern2,
  output logic [2:0] grant,
  output logic       busy,
  output logic [5:0] leds
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] slice_cnt_q, slice_cnt_d;
  logic [2:0]  grant_q, grant_d;
  logic        busy_q, busy_d;
  logic [5:0]  leds_q, leds_d;

  logic        slice_done;
  logic        others_req;
  logic        release_now;
  logic [1:0]  winner;

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  // The previous owner is searched last, so it only wins when nobody else asks.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] c1, c2;
    case (last)
      2'd0:    begin c1 = 2'd1; c2 = 2'd2; end
      2'd1:    begin c1 = 2'd2; c2 = 2'd0; end
      default: begin c1 = 2'd0; c2 = 2'd1; end
    endcase
    if (r[c1])      rr_pick = c1;
    else if (r[c2]) rr_pick = c2;
    else            rr_pick = last;
  endfunction

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    slice_cnt_d = slice_cnt_q;
    grant_d     = 3'b000;
    busy_d      = 1'b0;
    leds_d      = ~IDLE_PATTERN;

    winner      = rr_pick(req, last_q);
    slice_done  = (slice_cnt_q == (SLICE_CYCLES - 32'd1));
    others_req  = |(req & ~onehot(owner_q));
    release_now = (state_q == IDLE) || !req[owner_q] || (slice_done && others_req);

    if (release_now) begin
      slice_cnt_d = 32'd0;
      if (|req) begin
        state_d = OWNED;
        owner_d = winner;
        last_d  = winner;
      end else begin
        state_d = IDLE;
      end
    end else if (!slice_done) begin
      slice_cnt_d = slice_cnt_q + 32'd1;
    end

    // Outputs are loaded from the next state so they appear one edge after the request.
    if (state_d == OWNED) begin
      grant_d = onehot(owner_d);
      busy_d  = 1'b1;
      case (owner_d)
        2'd0:    leds_d = ~pattern0;
        2'd1:    leds_d = ~pattern1;
        default: leds_d = ~pattern2;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      last_q      <= 2'd2;
      slice_cnt_q <= 32'd0;
      grant_q     <= 3'b000;
      busy_q      <= 1'b0;
      leds_q      <= ~IDLE_PATTERN;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      slice_cnt_q <= slice_cnt_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      leds_q      <= leds_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign leds  = leds_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Randomized self-checking bench for led_arbiter against a queue-free behavioural
// model of round-robin ownership counted in whole cycles held.
module tb_led_arbiter;

  localparam int SLICE = 4;

  logic       clock;
  logic       reset;
  logic [2:0] req;
  logic [5:0] pattern0, pattern1, pattern2;
  logic [2:0] grant;
  logic       busy;
  logic [5:0] leds;

  int checks;
  int errors;

  int m_owner;
  int m_last;
  int m_held;

  led_arbiter #(
    .SLICE_CYCLES(32'd4),
    .IDLE_PATTERN(6'b000000)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .pattern0 (pattern0),
    .pattern1 (pattern1),
    .pattern2 (pattern2),
    .grant    (grant),
    .busy     (busy),
    .leds     (leds)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_owner = -1;
    m_last  = 2;
    m_held  = 0;
  endtask

  // One clock edge of arbitration: ownership lasts while requested, and at most
  // SLICE cycles when someone else is waiting; the search starts after the last winner.
  task automatic modelStep();
    bit rel;
    bit others;
    int nxt;
    rel = 1'b1;
    if (m_owner >= 0) begin
      others = 1'b0;
      for (int i = 0; i < 3; i++)
        if (i != m_owner && req[i]) others = 1'b1;
      rel = !req[m_owner] || (m_held >= SLICE && others);
    end
    if (rel) begin
      nxt = -1;
      for (int s = 1; s <= 3; s++) begin
        int c;
        c = (m_last + s) % 3;
        if (nxt < 0 && req[c]) nxt = c;
      end
      m_owner = nxt;
      if (nxt >= 0) begin
        m_last = nxt;
        m_held = 1;
      end else begin
        m_held = 0;
      end
    end else begin
      m_held++;
    end
  endtask

  function automatic logic [5:0] ownerPattern(input int k);
    if (k == 0) return pattern0;
    if (k == 1) return pattern1;
    return pattern2;
  endfunction

  task automatic checkAgainstModel();
    logic [2:0] exp_grant;
    logic [5:0] exp_leds;
    exp_grant = 3'b000;
    exp_leds  = 6'b111111;
    if (m_owner >= 0) begin
      exp_grant[m_owner] = 1'b1;
      exp_leds = ~ownerPattern(m_owner);
    end
    checkOutput("grant", {29'd0, grant}, {29'd0, exp_grant});
    checkOutput("busy",  {31'd0, busy},  {31'd0, (m_owner >= 0)});
    checkOutput("leds",  {26'd0, leds},  {26'd0, exp_leds});
  endtask

  // Drive inputs, clock once, advance the model with the sampled inputs, then check.
  // Called one time unit after a rising edge; patterns are held until the next call.
  task automatic applyStimulus(input logic [2:0] r, input logic [5:0] p0,
                               input logic [5:0] p1, input logic [5:0] p2);
    req      = r;
    pattern0 = p0;
    pattern1 = p1;
    pattern2 = p2;
    @(posedge clock);
    modelStep();
    #1;
    checkAgainstModel();
  endtask

  task automatic doReset();
    reset = 1'b1;
    req   = 3'b000;
    modelReset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] r;
    logic [2:0] seq_exp [16];
    checks   = 0;
    errors   = 0;
    req      = 3'b000;
    pattern0 = 6'h00;
    pattern1 = 6'h00;
    pattern2 = 6'h00;
    reset    = 1'b1;
    modelReset();
    #3;
    checkOutput("reset_grant", {29'd0, grant}, 32'd0);
    checkOutput("reset_busy",  {31'd0, busy},  32'd0);
    checkOutput("reset_leds",  {26'd0, leds},  32'h3f);
    doReset();

    // All three requesting: four cycles each, no gaps, starting with requester 0.
    for (int i = 0; i < 16; i++)
      seq_exp[i] = (i % 12 < 4) ? 3'b001 : (i % 12 < 8) ? 3'b010 : 3'b100;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(3'b111, 6'h11, 6'h22, 6'h0c);
      checkOutput($sformatf("rr_seq_%0d", i), {29'd0, grant}, {29'd0, seq_exp[i]});
    end

    // Lone requester keeps the grant past its slice; a contender takes over next edge.
    doReset();
    applyStimulus(3'b010, 6'h00, 6'b000101, 6'h00);
    checkOutput("solo_grant", {29'd0, grant}, 32'b010);
    checkOutput("solo_leds",  {26'd0, leds},  32'b111010);
    for (int i = 0; i < 20; i++) applyStimulus(3'b010, 6'h00, 6'b000101, 6'h00);
    checkOutput("solo_hold", {29'd0, grant}, 32'b010);
    applyStimulus(3'b011, 6'h15, 6'b000101, 6'h00);
    checkOutput("handover", {29'd0, grant}, 32'b001);

    // Owner drops with nobody else waiting: back to idle in one edge.
    applyStimulus(3'b000, 6'h15, 6'h05, 6'h00);
    checkOutput("idle_grant", {29'd0, grant}, 32'd0);
    checkOutput("idle_leds",  {26'd0, leds},  32'h3f);
    for (int i = 0; i < 3; i++) applyStimulus(3'b000, 6'h15, 6'h05, 6'h00);
    applyStimulus(3'b111, 6'h15, 6'h05, 6'h2a);
    checkOutput("resume_rr", {29'd0, grant}, 32'b010);

    // Owner pattern tracked with one cycle delay; non-owner pattern ignored.
    doReset();
    for (int i = 0; i < 8; i++)
      applyStimulus(3'b001, 6'($urandom), 6'($urandom), 6'($urandom));

    // Reset asserted mid-grant clears outputs without a clock edge.
    applyStimulus(3'b001, 6'h3f, 6'h00, 6'h00);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_grant", {29'd0, grant}, 32'd0);
    checkOutput("async_busy",  {31'd0, busy},  32'd0);
    checkOutput("async_leds",  {26'd0, leds},  32'h3f);
    modelReset();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Random traffic with sticky requests so slices expire and drops happen mid-slice.
    r = 3'b000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 2)] = ~r[$urandom_range(0, 2)];
      if ($urandom_range(0, 9) == 0) r = 3'($urandom);
      applyStimulus(r, 6'($urandom), 6'($urandom), 6'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
